// File: rtl/pe_feeder.sv
// ============================================================================
//  Module   : pe_feeder
//  Purpose  : Buffered (weight, activation) pair player for a systolic PE.
//             Pairs are loaded over a write port. A start plays them
//             back-to-back on fire/w/a, idles the stream for a flush
//             window and then pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_feeder #(
    parameter int DEPTH        = 16,
    parameter int DW           = 8,
    parameter int AW           = $clog2(DEPTH),
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_w,
    input  logic [DW-1:0] wr_a,
    output logic          wr_reject,
    input  logic [AW:0]   len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fire,
    output logic [DW-1:0] w,
    output logic [DW-1:0] a
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Outputs trail the state by one register stage, so the DONE-state cycle
    // already supplies the final idle output cycle. FLUSH therefore holds for
    // FLUSH_CYCLES-1 cycles and is skipped entirely when FLUSH_CYCLES is 1.
    localparam int             FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [AW:0]    DEPTH_N    = (AW+1)'(DEPTH);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   idx;
    logic [AW:0]     n_pairs;
    logic [FCW-1:0]  flush_cnt;
    logic [AW:0]     len_clamped;
    logic            ready;
    logic            accept;
    logic            last_pair;
    logic [2*DW-1:0] pair;

    logic            fire_nxt;
    logic [DW-1:0]   w_nxt;
    logic [DW-1:0]   a_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            reject_nxt;

    // Idle is judged as seen from outside: state IDLE and busy already low.
    // This places the first accepted start one cycle after busy falls.
    assign ready       = (state == S_IDLE) && !busy;
    assign accept      = start && ready;
    assign len_clamped = (len > DEPTH_N) ? DEPTH_N : len;
    assign last_pair   = ({1'b0, idx} == (n_pairs - (AW+1)'(1)));
    assign pair        = mem[idx];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (len == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_pair) begin
                    state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: values that the output registers take at the next edge
    always_comb begin
        fire_nxt   = (state == S_STREAM);
        w_nxt      = fire_nxt ? pair[2*DW-1:DW] : '0;
        a_nxt      = fire_nxt ? pair[DW-1:0]    : '0;
        busy_nxt   = (state != S_IDLE);
        done_nxt   = (state == S_DONE);
        reject_nxt = wr_en && !ready;
    end

    // Registered outputs, cleared asynchronously so a reset kills the stream at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire      <= 1'b0;
            w         <= '0;
            a         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_reject <= 1'b0;
        end else begin
            fire      <= fire_nxt;
            w         <= w_nxt;
            a         <= a_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            wr_reject <= reject_nxt;
        end
    end

    // Pair buffer; writes land only while idle, so playback never sees a torn update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && ready) begin
            mem[wr_addr] <= {wr_w, wr_a};
        end
    end

    // Play index, latched pair count and flush counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx       <= '0;
            n_pairs   <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                n_pairs <= len_clamped;
                idx     <= '0;
            end else if (state == S_STREAM && !last_pair) begin
                idx <= idx + AW'(1);
            end

            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + FCW'(1);
            end else begin
                flush_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_feeder.sv
// ============================================================================
//  Module   : tb_pe_feeder
//  Purpose  : Self-checking bench for pe_feeder. A cycle-indexed expectation
//             table is filled from the buffer contents and run timing at each
//             accepted start, and compared against the outputs every cycle.
//             Literal checks pin the pairs played and the done latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_feeder;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int FLUSH = 2;
    localparam int MAXC  = 1024;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_w    = '0;
    logic [DW-1:0] wr_a    = '0;
    logic [AW:0]   len     = '0;
    logic          start   = 1'b0;
    logic          wr_reject;
    logic          busy;
    logic          done;
    logic          fire;
    logic [DW-1:0] w;
    logic [DW-1:0] a;

    pe_feeder #(
        .DEPTH       (DEPTH),
        .DW          (DW),
        .AW          (AW),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_w     (wr_w),
        .wr_a     (wr_a),
        .wr_reject(wr_reject),
        .len      (len),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fire     (fire),
        .w        (w),
        .a        (a)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc is the index of the last rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation table, indexed by rising-edge number
    logic          e_fire [MAXC];
    logic [DW-1:0] e_w    [MAXC];
    logic [DW-1:0] e_a    [MAXC];
    logic          e_busy [MAXC];
    logic          e_done [MAXC];
    logic          e_rej  [MAXC];

    logic [2*DW-1:0] mbuf [DEPTH];
    int              free_edge = 0;
    int              start_k   = 0;

    int vectors = 0;
    int errors  = 0;

    logic [2*DW-1:0] obs[$];
    int              done_cnt = 0;
    int              done_cyc = 0;
    int              rej_cnt  = 0;

    task automatic chk(input string nm, input int act, input int req);
        vectors = vectors + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s at edge %0d: actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    task automatic clear_from(input int from);
        for (int i = from; i < MAXC; i++) begin
            if (i >= 0) begin
                e_fire[i] = 1'b0; e_w[i] = '0; e_a[i] = '0;
                e_busy[i] = 1'b0; e_done[i] = 1'b0; e_rej[i] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs and record what the run must look like
    task automatic step(input logic we, input int ad, input int ww, input int aa,
                        input logic st, input int ln);
        int k;
        int n;
        bit ok;
        @(negedge clk);
        wr_en   = we;
        wr_addr = AW'(ad);
        wr_w    = DW'(ww);
        wr_a    = DW'(aa);
        start   = st;
        len     = (AW+1)'(ln);
        k  = cyc + 1;
        ok = (k >= free_edge);
        if (we) begin
            if (ok) mbuf[ad] = {DW'(ww), DW'(aa)};
            else if (k < MAXC) e_rej[k] = 1'b1;
        end
        if (st && ok) begin
            start_k = k;
            n = (ln > DEPTH) ? DEPTH : ln;
            if (n == 0) begin
                e_busy[k+1] = 1'b1;
                e_done[k+1] = 1'b1;
                free_edge   = k + 3;
            end else begin
                for (int i = 0; i < n; i++) begin
                    e_fire[k+1+i] = 1'b1;
                    e_w[k+1+i]    = mbuf[i][2*DW-1:DW];
                    e_a[k+1+i]    = mbuf[i][DW-1:0];
                end
                for (int j = k + 1; j <= k + n + FLUSH; j++) e_busy[j] = 1'b1;
                e_done[k+n+FLUSH] = 1'b1;
                free_edge = k + n + FLUSH + 2;
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    // Per-cycle comparison against the expectation table
    always @(negedge clk) begin
        if (rstn && cyc < MAXC) begin
            chk("fire",      int'(fire),      int'(e_fire[cyc]));
            chk("w",         int'(w),         int'(e_w[cyc]));
            chk("a",         int'(a),         int'(e_a[cyc]));
            chk("busy",      int'(busy),      int'(e_busy[cyc]));
            chk("done",      int'(done),      int'(e_done[cyc]));
            chk("wr_reject", int'(wr_reject), int'(e_rej[cyc]));
        end
    end

    // Observation log used by the literal checks
    always @(negedge clk) begin
        if (rstn) begin
            if (fire) obs.push_back({w, a});
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (wr_reject) rej_cnt <= rej_cnt + 1;
        end
    end

    initial begin
        int d0;
        int r0;
        clear_from(0);
        for (int i = 0; i < DEPTH; i++) mbuf[i] = '0;

        // Reset state
        #3;
        chk("rst_fire", int'(fire), 0);
        chk("rst_w", int'(w), 0);
        chk("rst_a", int'(a), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_reject", int'(wr_reject), 0);
        @(negedge clk); #2; rstn = 1'b1;

        // Load buffer[i] = (i+1, 2i)
        for (int i = 0; i < DEPTH; i++) step(1'b1, i, i + 1, 2 * i, 1'b0, 0);
        idle(1);

        // Full-depth run
        obs.delete(); d0 = done_cnt;
        step(1'b0, 0, 0, 0, 1'b1, 16);
        idle(24);
        chk("full_count", obs.size(), 16);
        if (obs.size() == 16) begin
            chk("full_first_w", int'(obs[0][15:8]), 1);
            chk("full_first_a", int'(obs[0][7:0]), 0);
            chk("full_last_w", int'(obs[15][15:8]), 16);
            chk("full_last_a", int'(obs[15][7:0]), 30);
        end
        chk("full_done_pulses", done_cnt - d0, 1);
        chk("full_done_latency", done_cyc - start_k, 16 + FLUSH);

        // Short run
        obs.delete();
        step(1'b0, 0, 0, 0, 1'b1, 3);
        idle(10);
        chk("len3_count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("len3_p2_w", int'(obs[2][15:8]), 3);
            chk("len3_p2_a", int'(obs[2][7:0]), 4);
        end
        chk("len3_done_latency", done_cyc - start_k, 5);

        // Empty run, then clamped run
        obs.delete(); d0 = done_cnt;
        step(1'b0, 0, 0, 0, 1'b1, 0);
        idle(6);
        chk("len0_fires", obs.size(), 0);
        chk("len0_done_pulses", done_cnt - d0, 1);
        chk("len0_done_latency", done_cyc - start_k, 1);
        obs.delete();
        step(1'b0, 0, 0, 0, 1'b1, 20);
        idle(24);
        chk("len20_count", obs.size(), 16);

        // Write and restart while streaming
        obs.delete(); d0 = done_cnt; r0 = rej_cnt;
        step(1'b0, 0, 0, 0, 1'b1, 16);
        idle(3);
        step(1'b1, 2, 99, 1, 1'b0, 0);
        idle(2);
        step(1'b0, 0, 0, 0, 1'b1, 4);
        idle(22);
        chk("busy_reject_pulses", rej_cnt - r0, 1);
        chk("busy_done_pulses", done_cnt - d0, 1);
        chk("busy_run_count", obs.size(), 16);
        obs.delete();
        step(1'b0, 0, 0, 0, 1'b1, 3);
        idle(8);
        if (obs.size() == 3) chk("old_buf2_w", int'(obs[2][15:8]), 3);
        else chk("rerun_count", obs.size(), 3);

        // Same-cycle write and start
        obs.delete();
        step(1'b1, 0, 7, 5, 1'b1, 1);
        idle(6);
        chk("same_cycle_count", obs.size(), 1);
        if (obs.size() == 1) chk("same_cycle_pair", int'(obs[0]), int'({8'd7, 8'd5}));

        // Reset in the middle of a stream
        d0 = done_cnt;
        step(1'b0, 0, 0, 0, 1'b1, 16);
        step(1'b0, 0, 0, 0, 1'b0, 0);
        repeat (5) @(negedge clk);
        #2;
        chk("pre_rst_fire", int'(fire), 1);
        chk("pre_rst_w", int'(w), 5);
        chk("pre_rst_a", int'(a), 8);
        rstn = 1'b0;
        clear_from(cyc + 1);
        for (int i = 0; i < DEPTH; i++) mbuf[i] = '0;
        free_edge = 0;
        #1;
        chk("async_fire", int'(fire), 0);
        chk("async_w", int'(w), 0);
        chk("async_a", int'(a), 0);
        chk("async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #2; rstn = 1'b1;
        obs.delete();
        step(1'b0, 0, 0, 0, 1'b1, 1);
        idle(6);
        chk("rst_no_done", done_cnt - d0, 1);
        chk("post_rst_count", obs.size(), 1);
        if (obs.size() == 1) chk("post_rst_pair", int'(obs[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pe_feeder.md
# pe_feeder

Transmit-side driver for the systolic processing-element input stream. Holds a small buffer of (weight, activation) pairs loaded over a simple write port. On `start`, plays `len` pairs back-to-back into a PE (or the west/north edge of a PE row) on `fire`/`w`/`a`. Then idles the stream for a flush window so the PE accumulator settles, and pulses `done`. It replaces hand-driven stimulus as the producer of the PE's fire/w/a protocol.

## Interface
- `DEPTH`, 16: buffer entries, power of two, ≥ 2
- `DW`, 8: width of `w` and `a`
- `AW`, $clog2(DEPTH): buffer address width
- `FLUSH_CYCLES`, 2: idle cycles after the last pair before `done`, ≥ 1
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous assert, active-low
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  AW  buffer write address
- `wr_w`  in  DW  weight to store
- `wr_a`  in  DW  activation to store
- `wr_reject`  out  1  one-cycle pulse: write ignored because busy
- `len`  in  AW+1  pair count, sampled with `start`
- `start`  in  1  begin playback, honoured only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of run
- `fire`  out  1  PE fire: a valid pair is on `w`/`a` this cycle
- `w`  out  DW  PE weight
- `a`  out  DW  PE activation

## Operation
- Buffer: DEPTH × (2·DW) register file. Reset clears all entries to 0.
- Writes:
  - `wr_en` in IDLE writes {`wr_w`,`wr_a`} to `wr_addr` at the clock edge.
  - `wr_en` in any other state is dropped, and `wr_reject`=1 for the next cycle.
- FSM states:
  - IDLE → STREAM on `start` with `len`≥1. Latch `n` = min(`len`, DEPTH) and clear the index.
  - IDLE → DONE on `start` with `len`=0. No `fire` is issued.
  - STREAM: each cycle drives buffer[idx] with `fire`=1 and increments idx. Goes to FLUSH after idx = n-1 has been driven.
  - FLUSH: `fire`=0, `w`=`a`=0, for FLUSH_CYCLES cycles (counted) → DONE.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- `start` outside IDLE is ignored and is not queued.
- `len` > DEPTH is clamped to DEPTH.
- Indices never wrap. Playback is always buffer[0..n-1].
- Whenever `fire`=0, `w` and `a` are 0.

## Timing
- All outputs are registered. Reset values: `fire`=0, `w`=0, `a`=0, `busy`=0, `done`=0, `wr_reject`=0. State returns to IDLE and all indices/counters clear.
- `start` sampled at edge k: `busy`=1 from k+1. `fire`=1 with buffer[0] at k+1, buffer[i] at k+1+i, last pair at k+n.
- Edges k+n+1 … k+n+FLUSH_CYCLES: `fire`=0.
- `done`=1 in the cycle after edge k+n+FLUSH_CYCLES. `busy` falls one cycle later, so `busy` and `done` overlap for one cycle.
- `len`=0: `busy`=`done`=1 in the cycle after edge k+1; `fire` never rises.
- `fire` is contiguous for exactly n cycles, with no bubbles.
- `wr_en` and `start` in the same IDLE cycle: the write commits, and the stream uses the new data even when `wr_addr`=0.
- A new `start` is accepted in the first IDLE cycle after `done`. Minimum run-to-run spacing is n+FLUSH_CYCLES+2 cycles.
- `rstn` low mid-STREAM: `fire`/`w`/`a` drop to 0 asynchronously. No `done` is produced, and the buffer is cleared.

## Test plan
- Load buffer[i] = (w=i+1, a=2i) for i=0..15; `start` with `len`=16 → 16 contiguous `fire` cycles carrying (1,0),(2,2)…(16,30). Then 2 idle cycles, one `done` pulse, `busy` low afterwards.
- `len`=3 after the same load → only (1,0),(2,2),(3,4) with `fire`=1. `w`/`a`=0 afterwards. `done` in the cycle after edge k+3+FLUSH_CYCLES.
- `len`=0 → no `fire`; `busy`=`done`=1 in the cycle after edge k+1. `len`=20 → clamped to 16 pairs.
- `wr_en` to addr 2 (w=99) during STREAM → `wr_reject` pulses once, and a second run still plays the old buffer[2]. A `start` pulse during STREAM is ignored: exactly one `done`.
- Same-cycle `wr_en`(addr 0, w=7, a=5) and `start`(`len`=1) in IDLE → first and only pair is (7,5).
- `rstn` asserted at the 5th `fire` cycle → `fire`/`w`/`a`/`busy` go to 0 immediately, no `done`. After release, a `len`=1 run plays (0,0).
